// File: rtl/chunked_adder_if.sv
// Request/result bundle for chunked_adder: operand handshake in, registered result and flags out.
// The requester holds the master modport, the adder holds the slave modport.
interface chunked_adder_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             sub_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             ready_o;
  logic             done_o;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             zero_o;

  modport master (
    output start_i, sub_i, src1_i, src2_i,
    input  ready_o, done_o, sum_o, carry_o, overflow_o, zero_o
  );

  modport slave (
    input  start_i, sub_i, src1_i, src2_i,
    output ready_o, done_o, sum_o, carry_o, overflow_o, zero_o
  );
endinterface

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock with a registered ripple carry,
// producing the WIDTH-bit result plus carry, signed overflow and zero flags.
module chunked_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  chunked_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;       // already inverted for subtract
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_next;
  logic             carry_q;
  logic [CW-1:0]    k_q;
  logic [CHUNK:0]   chunk_sum;

  // NOTE: every variable written here is given a default first so no latch is inferred.
  always_comb begin
    chunk_sum = {1'b0, a_q[int'(k_q)*CHUNK +: CHUNK]}
              + {1'b0, b_q[int'(k_q)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    work_next = work_q;
    work_next[int'(k_q)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  // Decoded from state alone, so there is no combinational path from start_i.
  assign bus.ready_o = (state == IDLE);

  // NOTE: operand and work registers carry no reset; they are always written before being read.
  always_ff @(posedge clk_i) begin
    if (state == IDLE && bus.start_i) begin
      a_q <= bus.src1_i;
      b_q <= bus.sub_i ? ~bus.src2_i : bus.src2_i;
    end
    if (state == RUN) begin
      work_q <= work_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      k_q            <= '0;
      carry_q        <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.sum_o      <= '0;
      bus.carry_o    <= 1'b0;
      bus.overflow_o <= 1'b0;
      bus.zero_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            carry_q <= bus.sub_i;
            k_q     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          carry_q <= chunk_sum[CHUNK];
          if (k_q == LAST_K) begin
            bus.sum_o      <= work_next;
            bus.carry_o    <= chunk_sum[CHUNK];
            bus.overflow_o <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (work_next[WIDTH-1] != a_q[WIDTH-1]);
            bus.zero_o     <= (work_next == '0);
            bus.done_o     <= 1'b1;
            state          <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          bus.done_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: vector table on the 32/8 build, handshake and
// mid-operation reset sequences, and single vectors on 16/4 and 8/8 builds.
module tb_chunked_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_adder_if #(.WIDTH(32)) b32 ();
  chunked_adder_if #(.WIDTH(16)) b16 ();
  chunked_adder_if #(.WIDTH(8))  b8  ();

  chunked_adder #(.WIDTH(32), .CHUNK(8)) u32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  chunked_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk_i(clk), .rst_i(rst), .bus(b16));
  chunked_adder #(.WIDTH(8),  .CHUNK(8)) u8  (.clk_i(clk), .rst_i(rst), .bus(b8));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs [9];

  // One operation on the 32/8 instance, scrambling operands right after acceptance.
  task automatic op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic [31:0] es, input logic ec,
                      input logic ev, input logic ez);
    int n;
    @(negedge clk);
    check({tag, " ready idle"}, b32.ready_o, 1);
    b32.start_i = 1'b1;
    b32.src1_i  = a;
    b32.src2_i  = b;
    b32.sub_i   = sub;
    @(negedge clk);
    b32.start_i = 1'b0;
    b32.src1_i  = ~a;
    b32.src2_i  = a ^ b;
    b32.sub_i   = ~sub;
    check({tag, " ready busy"}, b32.ready_o, 0);
    n = 0;
    while (!b32.done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 4);
    check({tag, " sum"}, b32.sum_o, es);
    check({tag, " carry"}, b32.carry_o, ec);
    check({tag, " overflow"}, b32.overflow_o, ev);
    check({tag, " zero"}, b32.zero_o, ez);
    @(negedge clk);
    check({tag, " done width"}, b32.done_o, 0);
    check({tag, " ready back"}, b32.ready_o, 1);
    check({tag, " sum held"}, b32.sum_o, es);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    int          last_acc;
    int          c0;
    int          dones;
    logic        prev_done;
    logic [31:0] held;
    logic [31:0] ta;
    logic [31:0] tb;
    logic        ts;
    logic [32:0] r;
    int          acc_cyc [$];
    logic [31:0] exp_sum [$];
    logic        exp_c   [$];

    vecs[0] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};

    // Reset held two cycles with start asserted everywhere.
    rst = 1'b1;
    b32.start_i = 1'b1; b32.sub_i = 1'b0; b32.src1_i = 32'h1; b32.src2_i = 32'h2;
    b16.start_i = 1'b1; b16.sub_i = 1'b0; b16.src1_i = 16'h1; b16.src2_i = 16'h2;
    b8.start_i  = 1'b1; b8.sub_i  = 1'b0; b8.src1_i  = 8'h1;  b8.src2_i  = 8'h2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b32.start_i = 1'b0; b16.start_i = 1'b0; b8.start_i = 1'b0;
    check("rst ready", b32.ready_o, 1);
    check("rst done", b32.done_o, 0);
    check("rst sum", b32.sum_o, 0);
    check("rst flags", {b32.carry_o, b32.overflow_o, b32.zero_o}, 0);
    check("rst ready16", b16.ready_o, 1);
    check("rst ready8", b8.ready_o, 1);
    @(negedge clk);
    check("rst no start", b32.ready_o, 1);
    check("rst no done", b32.done_o, 0);

    for (int i = 0; i < 9; i++) begin
      op32($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
           vecs[i].sum, vecs[i].c, vecs[i].v, vecs[i].z);
    end

    // start_i held high with operands changing every cycle.
    held      = b32.sum_o;
    prev_done = 1'b0;
    last_acc  = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (b32.done_o) begin
        check("hs done width", prev_done, 0);
        if (acc_cyc.size() > 0) begin
          c0 = acc_cyc.pop_front();
          check("hs latency", cyc - c0, 5);
          check("hs sum", b32.sum_o, exp_sum.pop_front());
          check("hs carry", b32.carry_o, exp_c.pop_front());
        end else begin
          check("hs spurious done", 1, 0);
        end
        held = b32.sum_o;
      end else begin
        check("hs sum stable", b32.sum_o, held);
      end
      prev_done = b32.done_o;
      ta = 32'hA5A50000 ^ (cyc * 32'h01010101);
      tb = cyc * 32'h11111111 + 32'd3;
      ts = cyc[0];
      b32.start_i = (cyc < 31);
      b32.src1_i  = ta;
      b32.src2_i  = tb;
      b32.sub_i   = ts;
      if (b32.ready_o && b32.start_i) begin
        if (last_acc >= 0) check("hs spacing", cyc - last_acc, 6);
        last_acc = cyc;
        r = ts ? ({1'b0, ta} + {1'b0, ~tb} + 33'd1) : ({1'b0, ta} + {1'b0, tb});
        acc_cyc.push_back(cyc);
        exp_sum.push_back(r[31:0]);
        exp_c.push_back(r[32]);
      end
      @(negedge clk);
    end
    b32.start_i = 1'b0;
    check("hs drained", acc_cyc.size(), 0);
    check("hs last accept", last_acc, 30);

    // Reset on the second RUN edge aborts the operation.
    op32("pre", 32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0, 1'b0);
    b32.start_i = 1'b1; b32.src1_i = 32'h11111111; b32.src2_i = 32'h22222222; b32.sub_i = 1'b0;
    @(negedge clk);
    b32.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort done", b32.done_o, 0);
    check("abort sum", b32.sum_o, 0);
    check("abort flags", {b32.carry_o, b32.overflow_o, b32.zero_o}, 0);
    check("abort ready", b32.ready_o, 1);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b32.done_o) dones++;
    end
    check("abort no pulse", dones, 0);
    op32("post", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

    // WIDTH=16, CHUNK=4
    @(negedge clk);
    b16.start_i = 1'b1; b16.src1_i = 16'hFFFF; b16.src2_i = 16'h0001; b16.sub_i = 1'b0;
    @(negedge clk);
    b16.start_i = 1'b0; b16.src1_i = 16'h0;
    n = 0;
    while (!b16.done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w16 latency", n, 4);
    check("w16 sum", b16.sum_o, 16'h0000);
    check("w16 carry", b16.carry_o, 1);
    check("w16 zero", b16.zero_o, 1);
    check("w16 overflow", b16.overflow_o, 0);
    @(negedge clk);
    check("w16 done width", b16.done_o, 0);

    // WIDTH=8, CHUNK=8
    b8.start_i = 1'b1; b8.src1_i = 8'h40; b8.src2_i = 8'h40; b8.sub_i = 1'b0;
    @(negedge clk);
    b8.start_i = 1'b0; b8.src2_i = 8'h00;
    n = 0;
    while (!b8.done_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w8 latency", n, 1);
    check("w8 sum", b8.sum_o, 8'h80);
    check("w8 overflow", b8.overflow_o, 1);
    check("w8 carry", b8.carry_o, 0);
    check("w8 zero", b8.zero_o, 0);
    @(negedge clk);
    check("w8 done width", b8.done_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
